// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
//   Shared definitions for the sync_fifo elastic buffer:
//     - ptr_w()      : pointer width for a given depth ($clog2-based, min 1)
//     - RST_*        : reset values of the registered status flags
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

    // Width of a read/write pointer for a FIFO of 'depth' entries.
    // The occupancy counter is one bit wider so that it can hold 'depth'.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam logic RST_EMPTY     = 1'b1;
    localparam logic RST_FULL      = 1'b0;
    localparam logic RST_AEMPTY    = 1'b1;
    localparam logic RST_AFULL     = 1'b0;
    localparam logic RST_RD_VALID  = 1'b0;
    localparam logic RST_OVERFLOW  = 1'b0;
    localparam logic RST_UNDERFLOW = 1'b0;

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
//   DEPTH x WIDTH register array used as FIFO storage.
//   Ports:
//     clk        : clock, rising edge
//     rst        : synchronous active-high reset (read data register only)
//     i_wr_en    : write strobe
//     i_wr_addr  : write address
//     i_wr_data  : write data
//     i_rd_en    : read strobe; o_rd_data loads on the next edge
//     i_rd_addr  : read address
//     o_rd_data  : registered read data, holds when i_rd_en is low
// -----------------------------------------------------------------------------
module sync_fifo_mem #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    // NOTE: the storage array is deliberately left out of reset; only
    // entries that have been written are ever read, and a reset on every
    // word would prevent mapping onto plain register files or RAM.
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // NOTE: non-blocking assignments give read-before-write semantics: when
    // a full FIFO reads and writes the same slot in one cycle, the read
    // returns the old (oldest) word, not the one being written.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : sync_fifo_mem

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Parametrised single-clock FIFO with registered read port, occupancy
//   count and almost-full / almost-empty thresholds.
//   Optional feature macro: SYNC_FIFO_ERR_EN adds sticky overflow/underflow
//   flags and the err_clr input.
//   Ports:
//     clk          : clock, rising edge
//     rst          : synchronous active-high reset
//     wr_en        : write request
//     wr_data      : write data
//     rd_en        : read request
//     rd_data      : registered read data (holds when no read is accepted)
//     rd_valid     : high for the cycle after each accepted read
//     full/empty   : count == DEPTH / count == 0
//     almost_full  : count >= AFULL_TH
//     almost_empty : count <= AEMPTY_TH
//     count        : current occupancy
//     err_clr      : clears sticky flags            (SYNC_FIFO_ERR_EN)
//     overflow     : sticky, write rejected         (SYNC_FIFO_ERR_EN)
//     underflow    : sticky, read rejected          (SYNC_FIFO_ERR_EN)
// -----------------------------------------------------------------------------
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 8,
    parameter int AFULL_TH  = DEPTH - 1,
    parameter int AEMPTY_TH = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    rd_en,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    rd_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [ptr_w(DEPTH):0]   count
`ifdef SYNC_FIFO_ERR_EN
    ,
    input  logic                    err_clr,
    output logic                    overflow,
    output logic                    underflow
`endif
);

    localparam int AW = ptr_w(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_empty;
    logic          r_afull;
    logic          r_aempty;
    logic          r_rd_valid;

    logic          w_rd_accept;
    logic          w_wr_accept;
    logic [CW-1:0] w_count_nxt;

    // Requests arriving in a reset cycle are discarded. A write into a full
    // FIFO is accepted only when a read frees a slot in the same cycle; a
    // read from an empty FIFO is never satisfied by the concurrent write.
    assign w_rd_accept = !rst && rd_en && !r_empty;
    assign w_wr_accept = !rst && wr_en && (!r_full || w_rd_accept);

    // NOTE: every variable written in always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_accept, w_rd_accept})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers, count and flags. Flags come from the next-state count so
    // they are exact in the cycle following the edge that changed it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= RST_FULL;
            r_empty    <= RST_EMPTY;
            r_afull    <= RST_AFULL;
            r_aempty   <= RST_AEMPTY;
            r_rd_valid <= RST_RD_VALID;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count    <= w_count_nxt;
            r_full     <= (int'(w_count_nxt) == DEPTH);
            r_empty    <= (w_count_nxt == '0);
            r_afull    <= (int'(w_count_nxt) >= AFULL_TH);
            r_aempty   <= (int'(w_count_nxt) <= AEMPTY_TH);
            r_rd_valid <= w_rd_accept;
        end
    end

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_accept),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (wr_data),
        .i_rd_en   (w_rd_accept),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (rd_data)
    );

    assign rd_valid     = r_rd_valid;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign count        = r_count;

`ifdef SYNC_FIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;
    logic w_wr_reject;
    logic w_rd_reject;

    assign w_wr_reject = wr_en && r_full && !w_rd_accept;
    assign w_rd_reject = rd_en && r_empty;

    // A new error in the same cycle as err_clr takes priority, so no event
    // can slip through unreported.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= RST_OVERFLOW;
            r_underflow <= RST_UNDERFLOW;
        end else begin
            if (w_wr_reject) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_rd_reject) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
//   Directed bench for sync_fifo (default parameters: WIDTH=4, DEPTH=8,
//   AFULL_TH=7, AEMPTY_TH=1). Read data is checked by a scoreboard queue:
//   the stimulus pushes the expected word for every read it expects to be
//   accepted, and a monitor pops and compares on each rd_valid.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

    localparam int WIDTH = 4;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [3:0]       count;
`ifdef SYNC_FIFO_ERR_EN
    logic             err_clr;
    logic             overflow;
    logic             underflow;
`endif

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count)
`ifdef SYNC_FIFO_ERR_EN
        ,
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    always #5 clk = ~clk;

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [WIDTH-1:0] sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Occupancy and the four status flags for an expected count.
    task automatic check_status(input string tag, input int c);
        check({tag, "_count"},  32'(count),        32'(c));
        check({tag, "_full"},   32'(full),         32'(c == DEPTH));
        check({tag, "_empty"},  32'(empty),        32'(c == 0));
        check({tag, "_afull"},  32'(almost_full),  32'(c >= 7));
        check({tag, "_aempty"}, 32'(almost_empty), 32'(c <= 1));
    endtask

    // One clock of stimulus; 'push' queues the word the read must return.
    task automatic cyc(input logic w, input logic [WIDTH-1:0] d, input logic r,
                       input logic push, input logic [WIDTH-1:0] exp);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        if (push) sb.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    // Monitor: consumes scoreboard entries whenever the DUT presents data.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rd_valid: got rd_data=0x%0h, expected no read (t=%0t)",
                         rd_data, $time);
            end else begin
                logic [WIDTH-1:0] e;
                e = sb.pop_front();
                check("rd_data", 32'(rd_data), 32'(e));
            end
        end
        check("full_empty_exclusive", 32'(full & empty), 32'(0));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] mq[$];
        logic [WIDTH-1:0] e;

        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
`ifdef SYNC_FIFO_ERR_EN
        err_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_status("reset", 0);
        check("reset_rd_valid", 32'(rd_valid), 32'(0));
        check("reset_rd_data",  32'(rd_data),  32'(0));
`ifdef SYNC_FIFO_ERR_EN
        check("reset_overflow",  32'(overflow),  32'(0));
        check("reset_underflow", 32'(underflow), 32'(0));
`endif
        rst = 1'b0;

        // Fill with 1..8, then one write too many.
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b1, WIDTH'(k), 1'b0, 1'b0, '0);
            check_status($sformatf("fill%0d", k), k);
        end
        cyc(1'b1, 4'hF, 1'b0, 1'b0, '0);
        check_status("overwrite", 8);
`ifdef SYNC_FIFO_ERR_EN
        check("overflow_set", 32'(overflow), 32'(1));
`endif

        // Drain 1..8 in order, then one read too many.
        for (int j = 1; j <= 8; j++) begin
            cyc(1'b0, '0, 1'b1, 1'b1, WIDTH'(j));
            check_status($sformatf("drain%0d", j), 8 - j);
        end
        cyc(1'b0, '0, 1'b1, 1'b0, '0);
        check("underread_rd_valid", 32'(rd_valid), 32'(0));
        check("underread_hold",     32'(rd_data),  32'(8));
        check("drain_sb_empty",     32'(sb.size()), 32'(0));
        check_status("underread", 0);
`ifdef SYNC_FIFO_ERR_EN
        check("underflow_set",   32'(underflow), 32'(1));
        check("overflow_sticky", 32'(overflow),  32'(1));
        err_clr = 1'b1;
        idle();
        err_clr = 1'b0;
        check("overflow_clr",  32'(overflow),  32'(0));
        check("underflow_clr", 32'(underflow), 32'(0));
`endif

        // Full with simultaneous read and write of 0xA.
        for (int k = 1; k <= 8; k++) cyc(1'b1, WIDTH'(k), 1'b0, 1'b0, '0);
        cyc(1'b1, 4'hA, 1'b1, 1'b1, 4'h1);
        check_status("full_rw", 8);
`ifdef SYNC_FIFO_ERR_EN
        check("full_rw_no_overflow", 32'(overflow), 32'(0));
`endif
        for (int j = 2; j <= 8; j++) cyc(1'b0, '0, 1'b1, 1'b1, WIDTH'(j));
        cyc(1'b0, '0, 1'b1, 1'b1, 4'hA);
        check_status("full_rw_drained", 0);

        // Empty with simultaneous read and write of 0x5: read rejected.
        cyc(1'b1, 4'h5, 1'b1, 1'b0, '0);
        check("empty_rw_rd_valid", 32'(rd_valid), 32'(0));
        check_status("empty_rw", 1);
        cyc(1'b0, '0, 1'b1, 1'b1, 4'h5);
        check_status("empty_rw_read", 0);
`ifdef SYNC_FIFO_ERR_EN
        check("empty_rw_underflow", 32'(underflow), 32'(1));
        err_clr = 1'b1;
        idle();
        err_clr = 1'b0;
        check("empty_rw_underflow_clr", 32'(underflow), 32'(0));
`endif

        // Wrap-around: hold count at 3 while streaming 20 words through.
        mq.push_back(4'hB);
        mq.push_back(4'hC);
        mq.push_back(4'hD);
        cyc(1'b1, 4'hB, 1'b0, 1'b0, '0);
        cyc(1'b1, 4'hC, 1'b0, 1'b0, '0);
        cyc(1'b1, 4'hD, 1'b0, 1'b0, '0);
        check_status("wrap_pre", 3);
        for (int i = 0; i < 20; i++) begin
            mq.push_back(WIDTH'(i));
            e = mq.pop_front();
            cyc(1'b1, WIDTH'(i), 1'b1, 1'b1, e);
            check($sformatf("wrap_count%0d", i), 32'(count), 32'(3));
        end
        while (mq.size() != 0) begin
            e = mq.pop_front();
            cyc(1'b0, '0, 1'b1, 1'b1, e);
        end
        check_status("wrap_drained", 0);

        // Reset at count 5 with a write in flight.
        for (int k = 1; k <= 5; k++) cyc(1'b1, WIDTH'(k), 1'b0, 1'b0, '0);
        check_status("pre_rst", 5);
        rst = 1'b1;
        cyc(1'b1, 4'h7, 1'b0, 1'b0, '0);
        rst = 1'b0;
        check_status("mid_rst", 0);
        check("mid_rst_rd_valid", 32'(rd_valid), 32'(0));
        check("mid_rst_rd_data",  32'(rd_data),  32'(0));

        // Rejected read in the same cycle as err_clr.
`ifdef SYNC_FIFO_ERR_EN
        cyc(1'b0, '0, 1'b1, 1'b0, '0);
        check("post_rst_underflow", 32'(underflow), 32'(1));
        err_clr = 1'b1;
        cyc(1'b0, '0, 1'b1, 1'b0, '0);
        err_clr = 1'b0;
        check("clr_vs_set_underflow", 32'(underflow), 32'(1));
`else
        cyc(1'b0, '0, 1'b1, 1'b0, '0);
`endif
        check("post_rst_rd_valid", 32'(rd_valid), 32'(0));
        check_status("post_rst", 0);

        idle();
        idle();
        check("final_sb_empty", 32'(sb.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sync_fifo
